instr_sequencer: RTL and testbench

Instruction source for the processor's 16-bit `iin` input: the transmitting end of the instruction interface that the processor consumes.
- Holds a small program RAM that is loaded through a write port.
- On `start`, presents each stored word on `iin` for a fixed number of clocks, in order.
- After the last word it returns `iin` to 0 and pulses `done`.
- Replaces hand-timed bench stimulus and lets the processor run autonomously at top level.

---
 rtl/instr_sequencer.sv | 160 ++++++++++++++++
 tb/tb_instr_sequencer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: program RAM plus issue engine driving the processor's
// 16-bit instruction input. Words are loaded while idle. Once start is seen,
// words 0..len-1 are presented on iin in order, and done pulses at the end.
//
// Ports:
//   clock, resetn       clock and async active-low reset
//   load_we/addr/data   program RAM write port (accepted only when idle)
//   prog_len            words to issue (0..DEPTH, saturated), sampled on start
//   start               begin issuing from address 0 (accepted only when idle)
//   proc_done           (INSTR_SEQ_DONE_HANDSHAKE_EN only) processor finished word
//   iin, issue, pc      current word, first-clock strobe, current address
//   busy, done          run in progress, one-clock completion pulse
//
// Option macro: INSTR_SEQ_DONE_HANDSHAKE_EN. When it is defined, each word
// advances on proc_done instead of after HOLD clocks.
module instr_sequencer #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4,
   parameter int unsigned HOLD  = 4
) (
   input  logic          clock,
   input  logic          resetn,
   input  logic          load_we,
   input  logic [AW-1:0] load_addr,
   input  logic [15:0]   load_data,
   input  logic [AW:0]   prog_len,
   input  logic          start,
`ifdef INSTR_SEQ_DONE_HANDSHAKE_EN
   input  logic          proc_done,
`endif
   output logic [15:0]   iin,
   output logic          issue,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done
);

   localparam int unsigned DW = 16;
   localparam int unsigned CW = $clog2(HOLD + 1);

   typedef enum logic {IDLE, RUN} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW:0]     len_q, len_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [DW-1:0]   iin_q, iin_d;
   logic            issue_q, issue_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            mem_we;
   logic [AW:0]     len_sat;
   logic            step_now;
   logic            last_word;
   logic [DW-1:0]   mem_q [DEPTH];

   // Clamp the requested length to the RAM depth.
   assign len_sat = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;

   // The current word is the last one when pc+1 equals the latched length.
   assign last_word = (((AW+1)'(pc_q) + (AW+1)'(1)) == len_q);

`ifdef INSTR_SEQ_DONE_HANDSHAKE_EN
   // A nonzero cnt_q means the word has already been on iin for one full clock.
   assign step_now = proc_done && (cnt_q != '0);
`else
   assign step_now = (cnt_q == CW'(HOLD - 1));
`endif

   // Next-state and output logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      pc_d    = pc_q;
      iin_d   = iin_q;
      issue_d = 1'b0;
      busy_d  = busy_q;
      done_d  = 1'b0;
      mem_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (load_we) begin
               mem_we = 1'b1;
            end else if (start) begin
               if (len_sat == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
                  len_d   = len_sat;
                  pc_d    = '0;
                  iin_d   = mem_q[AW'(0)];
                  issue_d = 1'b1;
                  busy_d  = 1'b1;
                  cnt_d   = '0;
               end
            end
         end
         RUN: begin
`ifdef INSTR_SEQ_DONE_HANDSHAKE_EN
            cnt_d = CW'(1);
`else
            cnt_d = cnt_q + CW'(1);
`endif
            if (step_now) begin
               cnt_d = '0;
               if (last_word) begin
                  state_d = IDLE;
                  iin_d   = '0;
                  busy_d  = 1'b0;
                  pc_d    = '0;
                  done_d  = 1'b1;
               end else begin
                  pc_d    = pc_q + AW'(1);
                  iin_d   = mem_q[pc_q + AW'(1)];
                  issue_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         pc_q    <= '0;
         iin_q   <= '0;
         issue_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         pc_q    <= pc_d;
         iin_q   <= iin_d;
         issue_q <= issue_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Program RAM. Its contents are not reset.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem_q[load_addr] <= load_data;
      end
   end

   assign iin   = iin_q;
   assign issue = issue_q;
   assign pc    = pc_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer (default build, HOLD=4, DEPTH=16).
// A queue holds the expected output sequence of each program run. The queue
// is built from the word list and HOLD, and a compare process checks it on
// every falling edge. Literal checks pin the main timing points.
module tb_instr_sequencer;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned HOLD  = 4;

   typedef struct packed {
      logic [15:0]   iin;
      logic          issue;
      logic [AW-1:0] pc;
      logic          busy;
      logic          done;
   } exp_t;

   logic          clock = 1'b0;
   logic          resetn = 1'b0;
   logic          load_we = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [15:0]   load_data = '0;
   logic [AW:0]   prog_len = '0;
   logic          start = 1'b0;
   logic [15:0]   iin;
   logic          issue;
   logic [AW-1:0] pc;
   logic          busy;
   logic          done;

   exp_t        q[$];
   logic [15:0] mem_m [DEPTH];
   logic        exp_busy_now = 1'b0;
   int          checks = 0;
   int          failures = 0;

   always #5 clock = ~clock;

   instr_sequencer dut (
      .clock(clock), .resetn(resetn), .load_we(load_we), .load_addr(load_addr),
      .load_data(load_data), .prog_len(prog_len), .start(start),
      .iin(iin), .issue(issue), .pc(pc), .busy(busy), .done(done)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Expected behaviour of one start: HOLD clocks per word, then a done clock.
   task automatic model_start(input int len);
      int n;
      exp_t e;
      n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
      for (int i = 0; i < n; i++) begin
         for (int h = 0; h < int'(HOLD); h++) begin
            e.iin = mem_m[i]; e.issue = (h == 0); e.pc = AW'(i);
            e.busy = 1'b1; e.done = 1'b0;
            q.push_back(e);
         end
      end
      e = '0;
      e.done = 1'b1;
      q.push_back(e);
   endtask

   // Compare process: when the queue is empty, the idle output state is expected.
   always @(negedge clock) begin
      exp_t e;
      if (!resetn) e = '0;
      else if (q.size() > 0) e = q.pop_front();
      else e = '0;
      chk("iin", 32'(iin), 32'(e.iin));
      chk("issue", 32'(issue), 32'(e.issue));
      chk("pc", 32'(pc), 32'(e.pc));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      exp_busy_now = e.busy;
   end

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // Drive one cycle of inputs. Update the model if the DUT is idle at the coming edge.
   task automatic step(input logic we, input logic [AW-1:0] a, input logic [15:0] d,
                       input logic st, input logic [AW:0] len);
      load_we = we; load_addr = a; load_data = d; start = st; prog_len = len;
      if (!exp_busy_now) begin
         if (we) mem_m[a] = d;
         else if (st) model_start(int'(len));
      end
      tick();
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0);
   endtask

   logic [15:0] prog [4];

   initial begin
      prog[0] = 16'hA01C; prog[1] = 16'hA40A; prog[2] = 16'h2080; prog[3] = 16'h8000;

      // Test 1: reset values, then idle with no start.
      #12;
      chk("rst_iin", 32'(iin), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_issue", 32'(issue), 32'h0);
      @(negedge clock); #1;
      resetn = 1'b1;
      repeat (10) idle();
      chk("idle_iin", 32'(iin), 32'h0);

      // Test 2 with Test 4 interference: run 4 words, then try a write and a start mid-run.
      for (int i = 0; i < 4; i++) step(1'b1, AW'(i), prog[i], 1'b0, '0);
      step(1'b0, '0, '0, 1'b1, 5'd4);
      for (int c = 1; c <= 17; c++) begin
         if (c > 1) begin
            if (c == 6) step(1'b1, 4'd1, 16'hFFFF, 1'b1, 5'd4);
            else idle();
         end
         if (c <= 13 && ((c - 1) % 4) == 0) begin
            chk("t2_issue", 32'(issue), 32'h1);
            chk("t2_iin", 32'(iin), 32'(prog[(c - 1) / 4]));
            chk("t2_pc", 32'(pc), 32'((c - 1) / 4));
         end
         if (c == 16) chk("t2_last", 32'(iin), 32'h8000);
         if (c == 17) begin
            chk("t2_done", 32'(done), 32'h1);
            chk("t2_busy", 32'(busy), 32'h0);
            chk("t2_iin0", 32'(iin), 32'h0);
         end
      end
      idle();

      // Test 4 rerun: the second word is unchanged and the run length is the same.
      step(1'b0, '0, '0, 1'b1, 5'd4);
      for (int c = 2; c <= 17; c++) begin
         idle();
         if (c == 5) chk("t4_word1", 32'(iin), 32'hA40A);
         if (c == 16) chk("t4_busy16", 32'(busy), 32'h1);
      end
      chk("t4_done", 32'(done), 32'h1);

      // Start during the done cycle is accepted; then reset at the third word.
      step(1'b0, '0, '0, 1'b1, 5'd4);
      chk("b2b_busy", 32'(busy), 32'h1);
      for (int c = 2; c <= 9; c++) idle();
      chk("t5_word2", 32'(iin), 32'h2080);
      resetn = 1'b0;
      #1;
      chk("t5_async_iin", 32'(iin), 32'h0);
      chk("t5_async_busy", 32'(busy), 32'h0);
      q.delete();
      exp_busy_now = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      idle(); idle();
      step(1'b0, '0, '0, 1'b1, 5'd4);
      chk("t5_replay", 32'(iin), 32'hA01C);
      for (int c = 2; c <= 17; c++) idle();

      // Load and start in the same cycle: the start is ignored.
      step(1'b1, 4'd2, 16'h2080, 1'b1, 5'd4);
      chk("ldst_busy", 32'(busy), 32'h0);

      // Test 3: zero-length start, then a full 16-word program.
      step(1'b0, '0, '0, 1'b1, 5'd0);
      chk("t3_zdone", 32'(done), 32'h1);
      chk("t3_zbusy", 32'(busy), 32'h0);
      for (int i = 0; i < 16; i++) step(1'b1, AW'(i), 16'(16'h1100 + i * 16'h0111), 1'b0, '0);
      step(1'b0, '0, '0, 1'b1, 5'd16);
      for (int c = 2; c <= 65; c++) begin
         idle();
         if (c == 61) begin
            chk("t3_issue15", 32'(issue), 32'h1);
            chk("t3_pc15", 32'(pc), 32'd15);
         end
         if (c == 64) chk("t3_last", 32'(iin), 32'h20FF);
      end
      chk("t3_done", 32'(done), 32'h1);
      chk("t3_nowrap", 32'(iin), 32'h0);

      // A length above DEPTH is saturated to DEPTH.
      idle();
      step(1'b0, '0, '0, 1'b1, 5'd20);
      for (int c = 2; c <= 65; c++) idle();
      chk("sat_done", 32'(done), 32'h1);
      repeat (3) idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
